// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW+1R SRAM standing in for an OpenRAM macro: byte write mask,
// post-reset zero sweep, selectable read latency, write-first port-1 forwarding.
module sram_1rw1r_wmask #(
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  ADDR_WIDTH     = 6,
    parameter int unsigned  READ_LATENCY   = 1,
    parameter bit           CLEAR_ON_RESET = 1'b1,
    localparam int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    localparam int unsigned WMASK_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                   clk0,
    input  logic                   rst_n,
    output logic                   ready,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   collision
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
    logic                   ready_q;
    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic                   run_c, wr0_c, rd0_c, rd1_c, coll_c;
    logic [DATA_WIDTH-1:0]  old0_c, merged_c, rd1_data_c;
    logic                   mem_we_c;
    logic [ADDR_WIDTH-1:0]  mem_waddr_c;
    logic [DATA_WIDTH-1:0]  mem_wdata_c;

    assign run_c  = (state_q == ST_RUN);
    assign wr0_c  = run_c & ~csb0 & ~web0;
    assign rd0_c  = run_c & ~csb0 &  web0;
    assign rd1_c  = run_c & ~csb1;
    assign coll_c = wr0_c & rd1_c & (addr0 == addr1);
    assign old0_c = mem[addr0];

    // Byte-lane merge of the port-0 write into the currently stored word
    always_comb begin
        merged_c = old0_c;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask0[i]) merged_c[8*i +: 8] = din0[8*i +: 8];
        end
    end

    assign rd1_data_c  = coll_c ? merged_c : mem[addr1];
    assign mem_we_c    = rst_n & ((state_q == ST_CLEAR) | wr0_c);
    assign mem_waddr_c = (state_q == ST_CLEAR) ? cnt_q : addr0;
    assign mem_wdata_c = (state_q == ST_CLEAR) ? '0 : merged_c;

    // Storage carries no reset; contents are only changed by the sweep or writes
    always_ff @(posedge clk0) begin
        if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            ready_q <= !CLEAR_ON_RESET;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (&cnt_q) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;
    logic                  coll_q;

    // First read stage; collision stays aligned to the request edge
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q  <= '0;
            rd1_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_c;
            if (rd0_c) rd0_q <= old0_c;
            if (rd1_c) rd1_q <= rd1_data_c;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  rd0_v_q, rd1_v_q;
        logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

        always_ff @(posedge clk0 or negedge rst_n) begin
            if (!rst_n) begin
                rd0_v_q <= 1'b0;
                rd1_v_q <= 1'b0;
                dout0_q <= '0;
                dout1_q <= '0;
            end else begin
                rd0_v_q <= rd0_c;
                rd1_v_q <= rd1_c;
                if (rd0_v_q) dout0_q <= rd0_q;
                if (rd1_v_q) dout1_q <= rd1_q;
            end
        end

        assign dout0 = dout0_q;
        assign dout1 = dout1_q;
    end else begin : g_lat1
        assign dout0 = rd0_q;
        assign dout1 = rd1_q;
    end

    assign ready     = ready_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Randomised bench for sram_1rw1r_wmask: three configurations share stimulus
// and are compared against a word-array reference model.
module tb_sram_1rw1r_wmask;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clk0 = 1'b0;
    logic          rst_n;
    logic          csb0, web0, csb1;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;

    logic          rdy_a, rdy_b, rdy_c;
    logic          col_a, col_b, col_c;
    logic [DW-1:0] d0_a, d1_a, d0_b, d1_b, d0_c, d1_c;

    sram_1rw1r_wmask u_lat1 (
        .clk0(clk0), .rst_n(rst_n), .ready(rdy_a), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(d0_a), .csb1(csb1),
        .addr1(addr1), .dout1(d1_a), .collision(col_a));

    sram_1rw1r_wmask #(.READ_LATENCY(2)) u_lat2 (
        .clk0(clk0), .rst_n(rst_n), .ready(rdy_b), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(d0_b), .csb1(csb1),
        .addr1(addr1), .dout1(d1_b), .collision(col_b));

    sram_1rw1r_wmask #(.CLEAR_ON_RESET(1'b0)) u_noclr (
        .clk0(clk0), .rst_n(rst_n), .ready(rdy_c), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(d0_c), .csb1(csb1),
        .addr1(addr1), .dout1(d1_c), .collision(col_c));

    always #5 clk0 = ~clk0;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] e0_l1, e1_l1, e0_l2, e1_l2;
    logic          ecol;
    bit            nc_valid;
    int            n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
        e0_l1 = '0; e1_l1 = '0; e0_l2 = '0; e1_l2 = '0; ecol = 1'b0;
    endtask

    // One clock edge: predict from the pre-edge inputs, then compare all configs
    task automatic cycle();
        logic [DW-1:0] merged, n0, n1;
        logic          wr, r0, r1, col;
        wr = !csb0 && !web0;
        r0 = !csb0 && web0;
        r1 = !csb1;
        merged = mdl_mem[addr0];
        for (int i = 0; i < 4; i++) if (wmask0[i]) merged[8*i +: 8] = din0[8*i +: 8];
        col = wr && r1 && (addr0 == addr1);
        n0  = r0 ? mdl_mem[addr0] : e0_l1;
        n1  = r1 ? (col ? merged : mdl_mem[addr1]) : e1_l1;
        @(posedge clk0); #1;
        if (wr) mdl_mem[addr0] = merged;
        e0_l2 = e0_l1; e1_l2 = e1_l1;
        e0_l1 = n0;    e1_l1 = n1;    ecol = col;
        check_eq("l1_dout0", d0_a, e0_l1);
        check_eq("l1_dout1", d1_a, e1_l1);
        check_eq("l1_coll", DW'(col_a), DW'(ecol));
        check_eq("l2_dout0", d0_b, e0_l2);
        check_eq("l2_dout1", d1_b, e1_l2);
        check_eq("l2_coll", DW'(col_b), DW'(ecol));
        check_eq("ready_run", DW'({rdy_a, rdy_b, rdy_c}), DW'(3'b111));
        if (nc_valid) begin
            check_eq("nc_dout0", d0_c, e0_l1);
            check_eq("nc_dout1", d1_c, e1_l1);
            check_eq("nc_coll", DW'(col_c), DW'(ecol));
        end
    endtask

    task automatic op(input logic c0, input logic w0, input logic [3:0] m, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d, input logic c1, input logic [AW-1:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
        cycle();
    endtask

    task automatic idle();
        op(1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge
    task automatic assert_reset();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
        rst_n = 1'b0;
        #1;
        mdl_reset();
        nc_valid = 0;
        check_eq("rst_dout0", d0_a | d0_b | d0_c, '0);
        check_eq("rst_dout1", d1_a | d1_b | d1_c, '0);
        check_eq("rst_coll", DW'({col_a, col_b, col_c}), '0);
        check_eq("rst_ready_clr", DW'({rdy_a, rdy_b}), '0);
        check_eq("rst_ready_noclr", DW'(rdy_c), DW'(1'b1));
    endtask

    task automatic release_reset();
        @(posedge clk0); #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_sweep(input int n_edges);
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk0); #1;
            check_eq("clr_ready_l1", DW'(rdy_a), DW'(e == int'(DEPTH)));
            check_eq("clr_ready_l2", DW'(rdy_b), DW'(e == int'(DEPTH)));
            check_eq("clr_ready_nc", DW'(rdy_c), DW'(1'b1));
        end
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1;
        n_checks = 0; n_fail = 0; nc_valid = 0;
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
        rst_n = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk0);
        #1;
        assert_reset();
        release_reset();
        clear_sweep(DEPTH);

        for (int a = 0; a < int'(DEPTH); a++) op(1'b1, 1'b1, 4'h0, '0, '0, 1'b0, AW'(a));
        idle();

        // Full-mask fill so the no-clear instance has known contents
        for (int a = 0; a < int'(DEPTH); a++) op(1'b0, 1'b0, 4'hF, AW'(a), $urandom, 1'b1, '0);
        nc_valid = 1;
        op(1'b0, 1'b1, 4'h0, '0, '0, 1'b0, '0);

        op(1'b0, 1'b0, 4'hF,    AW'(5), 32'hAABBCCDD, 1'b1, '0);
        op(1'b0, 1'b0, 4'b0101, AW'(5), 32'h11223344, 1'b1, '0);
        op(1'b0, 1'b1, 4'h0,    AW'(5), '0,           1'b1, '0);
        check_eq("mask_rd_l1", d0_a, 32'hAA22CC44);
        idle();
        check_eq("mask_rd_l2", d0_b, 32'hAA22CC44);

        op(1'b0, 1'b0, 4'hF, AW'(9), 32'h0,        1'b1, '0);
        op(1'b0, 1'b0, 4'hF, AW'(9), 32'hDEADBEEF, 1'b0, AW'(9));
        check_eq("coll_fwd_l1", d1_a, 32'hDEADBEEF);
        check_eq("coll_pulse_hi", DW'({col_a, col_b}), DW'(2'b11));
        idle();
        check_eq("coll_pulse_lo", DW'({col_a, col_b}), '0);
        check_eq("coll_fwd_l2", d1_b, 32'hDEADBEEF);

        for (int a = 1; a <= 3; a++) op(1'b0, 1'b0, 4'hF, AW'(a), DW'(a), 1'b1, '0);
        for (int a = 1; a <= 3; a++) op(1'b0, 1'b1, 4'h0, AW'(a), '0, 1'b1, '0);
        idle();
        idle();
        check_eq("lat2_hold", d0_b, 32'h3);

        for (int n = 0; n < 400; n++) begin
            ra0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra1 = ($urandom_range(0, 2) == 0) ? ra0 : AW'($urandom);
            op(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), ra0, $urandom,
               1'($urandom_range(0, 3) == 0), ra1);
        end

        op(1'b0, 1'b0, 4'hF, AW'(63), 32'h5A5A5A5A, 1'b1, '0);
        op(1'b0, 1'b1, 4'h0, AW'(63), '0, 1'b0, AW'(63));
        check_eq("a63_nc_d0", d0_c, 32'h5A5A5A5A);
        check_eq("a63_nc_d1", d1_c, 32'h5A5A5A5A);
        check_eq("a63_nc_coll", DW'(col_c), '0);

        assert_reset();
        release_reset();
        clear_sweep(30);
        assert_reset();
        release_reset();
        clear_sweep(DEPTH);

        for (int a = 0; a < int'(DEPTH); a++) op(1'b0, 1'b1, 4'h0, AW'(DEPTH - 1 - a), '0, 1'b0, AW'(a));
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_wmask.md
# sram_1rw1r_wmask

Parametrised behavioural 1RW+1R SRAM for RTL simulation and FPGA prototyping, standing in for the OpenRAM macros. It has real storage, per-byte write masks, a selectable read latency, a post-reset zero-clear sweep and write-first forwarding on port collisions. Both ports share one clock and sit where a macro instance would sit.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 6, address width
- RAM_DEPTH, 1 << ADDR_WIDTH, words (derived, not overridable)
- WMASK_WIDTH, DATA_WIDTH/8, byte-lane count (derived)
- READ_LATENCY, 1, 1 or 2 clock edges from request to dout update
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents untouched
- clk0  input  1  single clock, rising edge; both ports use it
- rst_n  input  1  asynchronous, active-low reset
- ready  output  1  high when the RUN state accepts requests
- csb0  input  1  port 0 active-low chip select
- web0  input  1  port 0 active-low write enable
- wmask0  input  WMASK_WIDTH  port 0 byte write mask; bit i enables din0[8i+7:8i]
- addr0  input  ADDR_WIDTH  port 0 address
- din0  input  DATA_WIDTH  port 0 write data
- dout0  output  DATA_WIDTH  port 0 read data, registered
- csb1  input  1  port 1 active-low chip select
- addr1  input  ADDR_WIDTH  port 1 address
- dout1  output  DATA_WIDTH  port 1 read data, registered
- collision  output  1  one-cycle pulse: port 1 read hit the same-cycle port 0 write address

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR:
  - A counter starting at 0 writes all-zero to mem[cnt] on each edge.
  - After cnt = RAM_DEPTH-1 is written, the FSM moves to RUN.
  - csb0 and csb1 are ignored (treated as 1); no requests are lost-tracked.
- Port 0 write (RUN, csb0=0, web0=0): byte lane i of mem[addr0] takes din0 lane i where wmask0[i]=1. Other lanes are unchanged. wmask0=0 is a legal no-op. dout0 holds.
- Port 0 read (RUN, csb0=0, web0=1): dout0 <= mem[addr0] after READ_LATENCY.
- Port 1 read (RUN, csb1=0): dout1 <= mem[addr1] after READ_LATENCY.
- Deselected port: its dout holds its last value.
- Collision: a port 0 write and a port 1 read with addr0 == addr1 in the same cycle.
  - dout1 returns the post-write merged word (write-first).
  - collision is high for the one cycle after the request edge.
- Two reads of the same address on both ports: no collision; both return the data.
- No out-of-range addresses exist (depth is a power of two).

## Timing
- Reset values: dout0 = 0, dout1 = 0, collision = 0, ready = 0 (CLEAR_ON_RESET=1) or 1 (CLEAR_ON_RESET=0). The clear counter resets to 0.
- Clear duration: ready rises after exactly RAM_DEPTH rising edges following rst_n deassertion (64 at defaults).
- Reset mid-clear: the counter returns to 0 and the full sweep restarts. Reset mid-read: in-flight pipeline data is discarded and douts go to 0.
- Read latency:
  - READ_LATENCY=1: a request sampled at edge k updates dout at edge k.
  - READ_LATENCY=2: the update moves to edge k+1 through one extra output register.
  - Back-to-back reads sustain one result per cycle.
- Write to read: a write at edge k is visible to a read sampled at edge k+1 on either port. The same-edge case is port 1 only, via forwarding.
- collision timing:
  - It asserts after edge k and deasserts after edge k+1 unless another collision occurs.
  - With READ_LATENCY=2 it stays aligned to the request, not to the dout update.

## Test plan
- Reset and clear (defaults): release rst_n, then count edges -> ready=0 for 64 edges, then 1. Read all 64 addresses on port 1 -> every dout1 = 0x00000000.
- Masked write: write 0xAABBCCDD to addr 5 with wmask0=4'b1111, then 0x11223344 with wmask0=4'b0101, then read port 0 -> dout0 = 0xAA22CC44.
- Collision forwarding: mem[9]=0x0, then in the same cycle write 0xDEADBEEF (mask 1111) on port 0 and read addr 9 on port 1 -> dout1 = 0xDEADBEEF and collision pulses high for exactly 1 cycle.
- Latency sweep: with READ_LATENCY=2, issue reads at addrs 1,2,3 on consecutive edges after writing 0x1,0x2,0x3 -> dout0 shows 0x1,0x2,0x3 on edges k+1,k+2,k+3, and holds 0x3 once csb0=1.
- Reset mid-clear: assert rst_n low at clear count 30, release -> ready stays 0 for a full 64 edges. Reset mid-operation -> dout0, dout1, collision return to 0 immediately (asynchronously).
- CLEAR_ON_RESET=0: after reset ready=1 at once. A write of 0x5A5A5A5A at addr 63 followed by a read on both ports -> both douts = 0x5A5A5A5A, collision = 0.
